// File: rtl/mealy_fsm_decoder.sv
// Serial decoder for the 4-state P/Q/R/T Mealy bit encoder.
// Recovers the source bits, packs them LSB-first into words and hands them out over valid/ready.
module mealy_fsm_decoder #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic                      i_bit,
    input  logic                      i_sof,
    input  logic                      i_ready,
    input  logic                      i_clr_err,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_bit_valid,
    output logic                      o_bit,
    output logic [1:0]                o_state,
    output logic [$clog2(DATA_W)-1:0] o_bit_cnt,
    output logic                      o_overflow,
    output logic                      o_frame_err
);

    localparam int unsigned CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [1:0] ST_P = 2'b00;
    localparam logic [1:0] ST_Q = 2'b01;
    localparam logic [1:0] ST_R = 2'b10;
    localparam logic [1:0] ST_T = 2'b11;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_bit_valid;
    logic              r_bit;
    logic              r_overflow;
    logic              r_frame_err;

    logic              w_sof;
    logic [1:0]        w_es;
    logic              w_x;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     w_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_done;
    logic              w_accept;
    logic              w_free;
    logic              w_load;
    logic              w_drop;
    logic              w_resync;
    logic [DATA_W-1:0] w_word;

    assign w_sof = i_valid & i_sof;
    assign w_es  = w_sof ? ST_P : r_state;
    // The encoder emits x XOR ~state[0]; the same XOR undoes it.
    assign w_x   = i_bit ^ ~w_es[0];

    always_comb begin
        w_state_nxt = r_state;
        case (w_es)
            ST_P:    w_state_nxt = w_x ? ST_T : ST_R;
            ST_Q:    w_state_nxt = w_x ? ST_Q : ST_P;
            ST_R:    w_state_nxt = w_x ? ST_R : ST_Q;
            ST_T:    w_state_nxt = w_x ? ST_P : ST_R;
            default: w_state_nxt = ST_P;
        endcase
    end

    assign w_cnt     = w_sof ? '0 : r_bit_cnt;
    assign w_done    = i_valid & (w_cnt == LAST);
    assign w_cnt_nxt = w_done ? '0 : w_cnt + 1'b1;
    assign w_resync  = w_sof & (r_bit_cnt != '0);

    always_comb begin
        w_word        = w_sof ? '0 : r_shift;
        w_word[w_cnt] = w_x;
    end

    assign w_accept = r_valid & i_ready;
    assign w_free   = ~r_valid | i_ready;
    assign w_load   = w_done & w_free;
    assign w_drop   = w_done & ~w_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_P;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_bit_valid <= 1'b0;
            r_bit       <= 1'b0;
        end else begin
            r_bit_valid <= i_valid;
            r_bit       <= w_x;
            if (i_valid) begin
                r_state   <= w_state_nxt;
                r_bit_cnt <= w_cnt_nxt;
                r_shift   <= w_done ? '0 : w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_resync) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_bit_valid = r_bit_valid;
    assign o_bit       = r_bit;
    assign o_state     = r_state;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;

endmodule
